// File: rtl/conv_window_3x3_if.sv
// Valid/ready stream bundles around the 3x3 window generator: a pixel stream
// in from the FIFO read port and a window stream out to the MAC array.
interface pix_stream_if #(
  parameter int W = 8
);
  logic [W-1:0] data_in;
  logic         data_in_valid;
  logic         data_in_ready;

  modport master (output data_in, output data_in_valid, input data_in_ready);
  modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

interface win_stream_if #(
  parameter int W = 8
);
  logic [9*W-1:0] win_data;
  logic           win_valid;
  logic           win_ready;
  logic           win_sof;
  logic           win_eol;
  logic           win_eof;

  modport master (output win_data, output win_valid, output win_sof,
                  output win_eol, output win_eof, input win_ready);
  modport slave  (input win_data, input win_valid, input win_sof,
                  input win_eol, input win_eof, output win_ready);
endinterface

// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window generator over two line buffers; window valid 1 cycle after the pixel is accepted.
// Single output register, no skid: input ready = ~win_valid | win_ready, so a stalled window blocks the FIFO.
module conv_window_3x3 #(
  parameter int W     = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  pix_stream_if.slave  pix_i,
  win_stream_if.master win_o
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [W-1:0]     lb0_q [IMG_W];
  logic [W-1:0]     lb1_q [IMG_W];
  logic [W-1:0]     win_q [3][3];
  logic [W-1:0]     win_d [3][3];
  logic             vld_q, vld_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             eof_q, eof_d;

  logic         rdy;
  logic         acc;
  logic [W-1:0] t0;
  logic [W-1:0] t1;
  logic         col_end;
  logic         row_end;
  logic         in_region;

  assign rdy   = ~vld_q | win_o.win_ready;
  assign acc   = pix_i.data_in_valid & rdy;
  assign t0    = lb0_q[col_q];
  assign t1    = lb1_q[col_q];

  assign col_end   = (col_q == COL_LAST);
  assign row_end   = (row_q == ROW_LAST);
  assign in_region = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  assign pix_i.data_in_ready = rdy;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Column c2 takes {line row-2, line row-1, current pixel} top to bottom.
  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = t1;
      win_d[1][2] = t0;
      win_d[2][2] = pix_i.data_in;
    end
  end

  always_comb begin
    vld_d = vld_q;
    sof_d = sof_q;
    eol_d = eol_q;
    eof_d = eof_q;
    if (acc) begin
      vld_d = in_region;
      sof_d = in_region && (row_q == ROW_TWO) && (col_q == COL_TWO);
      eol_d = in_region && col_end;
      eof_d = in_region && col_end && row_end;
    end else if (win_o.win_ready) begin
      vld_d = 1'b0;
      sof_d = 1'b0;
      eol_d = 1'b0;
      eof_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      vld_q <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= vld_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
      eof_q <= eof_d;
      win_q <= win_d;
    end
  end

  // Line buffers carry no reset; the row>=2 gate keeps stale lines out of any window.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1_q[col_q] <= t0;
      lb0_q[col_q] <= pix_i.data_in;
    end
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign win_o.win_data[W*(3*gr+gc) +: W] = win_q[gr][gc];
    end
  end

  assign win_o.win_valid = vld_q;
  assign win_o.win_sof   = sof_q;
  assign win_o.win_eol   = eol_q;
  assign win_o.win_eof   = eof_q;
endmodule

// File: tb/tb_conv_window_3x3.sv
// Bench for conv_window_3x3: a 4x4 instance driven from a scenario table plus
// stall/reset sequences, and a 40x30 instance under random valid/ready with a golden image.
module tb_conv_window_3x3;
  localparam int W  = 8;
  localparam int BW = 40;
  localparam int BH = 30;

  typedef struct packed {
    logic [9*W-1:0] d;
    logic           sof;
    logic           eol;
    logic           eof;
  } exp_t;

  typedef struct {
    int gap;
    int frames;
    bit rnd_ready;
    int exp_win;
    int exp_sof;
    int exp_eol;
    int exp_eof;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  pix_stream_if #(.W(W)) s_pix ();
  win_stream_if #(.W(W)) s_win ();
  pix_stream_if #(.W(W)) b_pix ();
  win_stream_if #(.W(W)) b_win ();

  conv_window_3x3 #(.W(W), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_i(s_pix), .win_o(s_win));
  conv_window_3x3 #(.W(W), .IMG_W(BW), .IMG_H(BH)) dut_big (
    .clk(clk), .rst_n(rst_n), .pix_i(b_pix), .win_o(b_win));

  int n_vec = 0;
  int n_err = 0;
  exp_t sq[$];
  exp_t bq[$];
  int s_cnt, s_sof, s_eol, s_eof, s_vcyc;
  int b_cnt, b_sof, b_eol, b_eof;
  int s_rmode = 0, b_rmode = 0;
  logic s_rnd = 1'b1, b_rnd = 1'b1, s_man = 1'b1;
  logic [W-1:0] img [BH][BW];
  vec_t tbl [4];

  assign s_win.win_ready = (s_rmode == 1) ? s_rnd : (s_rmode == 2) ? s_man : 1'b1;
  assign b_win.win_ready = (b_rmode == 1) ? b_rnd : 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_rnd = 1'($urandom_range(0, 1));
      b_rnd = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  function automatic exp_t s_exp(input int f, input int r, input int c);
    exp_t e;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        e.d[W*(3*wr+wc) +: W] = W'(16*f + 4*(r-2+wr) + (c-2+wc));
    e.sof = (r == 2 && c == 2);
    e.eol = (c == 3);
    e.eof = (r == 3 && c == 3);
    return e;
  endfunction

  function automatic exp_t b_exp(input int r, input int c);
    exp_t e;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        e.d[W*(3*wr+wc) +: W] = img[r-2+wr][c-2+wc];
    e.sof = (r == 2 && c == 2);
    e.eol = (c == BW-1);
    e.eof = (r == BH-1 && c == BW-1);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && s_win.win_valid) begin
      s_vcyc++;
      if (s_win.win_ready) begin
        s_cnt++;
        s_sof += int'(s_win.win_sof);
        s_eol += int'(s_win.win_eol);
        s_eof += int'(s_win.win_eof);
        if (sq.size() == 0) chk("s_unexpected_window", 128'(s_win.win_data), 128'hx);
        else chk("s_window", 128'({s_win.win_data, s_win.win_sof, s_win.win_eol, s_win.win_eof}),
                 128'(sq.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_win.win_valid && b_win.win_ready) begin
      b_cnt++;
      b_sof += int'(b_win.win_sof);
      b_eol += int'(b_win.win_eol);
      b_eof += int'(b_win.win_eof);
      if (bq.size() == 0) chk("b_unexpected_window", 128'(b_win.win_data), 128'hx);
      else chk("b_window", 128'({b_win.win_data, b_win.win_sof, b_win.win_eol, b_win.win_eof}),
               128'(bq.pop_front()));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_cnt = 0; s_sof = 0; s_eol = 0; s_eof = 0; s_vcyc = 0;
  endtask

  task automatic s_send(input int f, input int r, input int c);
    bit done = 0;
    s_pix.data_in = W'(16*f + 4*r + c);
    s_pix.data_in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (s_pix.data_in_ready) begin
        if (r >= 2 && c >= 2) sq.push_back(s_exp(f, r, c));
        done = 1;
      end
      @(posedge clk); #1;
    end
    s_pix.data_in_valid = 1'b0;
    if (!done) chk("s_send_timeout", 128'(0), 128'(1));
    else chk("s_vld_after_acc", 128'(s_win.win_valid), 128'(r >= 2 && c >= 2));
  endtask

  task automatic b_send(input int r, input int c);
    bit done = 0;
    b_pix.data_in = img[r][c];
    b_pix.data_in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (b_pix.data_in_ready) begin
        if (r >= 2 && c >= 2) bq.push_back(b_exp(r, c));
        done = 1;
      end
      @(posedge clk); #1;
    end
    b_pix.data_in_valid = 1'b0;
    if (!done) chk("b_send_timeout", 128'(0), 128'(1));
    else chk("b_vld_after_acc", 128'(b_win.win_valid), 128'(r >= 2 && c >= 2));
  endtask

  task automatic s_drain();
    s_rmode = 0;
    for (int k = 0; k < 50 && sq.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("s_drain_empty", 128'(sq.size()), 128'(0));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, 128'(s_win.win_valid), 128'(0));
    chk({nm, "_data"},  128'(s_win.win_data),  128'(0));
    chk({nm, "_flags"}, 128'({s_win.win_sof, s_win.win_eol, s_win.win_eof}), 128'(0));
    chk({nm, "_ready"}, 128'(s_pix.data_in_ready), 128'(1));
  endtask

  initial begin
    tbl[0] = '{gap: 0, frames: 1, rnd_ready: 0, exp_win: 4,  exp_sof: 1, exp_eol: 2, exp_eof: 1};
    tbl[1] = '{gap: 2, frames: 1, rnd_ready: 0, exp_win: 4,  exp_sof: 1, exp_eol: 2, exp_eof: 1};
    tbl[2] = '{gap: 0, frames: 2, rnd_ready: 0, exp_win: 8,  exp_sof: 2, exp_eol: 4, exp_eof: 2};
    tbl[3] = '{gap: 1, frames: 3, rnd_ready: 1, exp_win: 12, exp_sof: 3, exp_eol: 6, exp_eof: 3};

    s_pix.data_in = '0; s_pix.data_in_valid = 1'b0;
    b_pix.data_in = '0; b_pix.data_in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_in");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("reset_after");

    for (int t = 0; t < 4; t++) begin
      do_reset();
      s_rmode = tbl[t].rnd_ready ? 1 : 0;
      for (int f = 0; f < tbl[t].frames; f++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            s_send(f, r, c);
            repeat (tbl[t].gap) begin @(posedge clk); #1; end
          end
      s_drain();
      chk($sformatf("t%0d_windows", t), 128'(s_cnt), 128'(tbl[t].exp_win));
      chk($sformatf("t%0d_sof", t), 128'(s_sof), 128'(tbl[t].exp_sof));
      chk($sformatf("t%0d_eol", t), 128'(s_eol), 128'(tbl[t].exp_eol));
      chk($sformatf("t%0d_eof", t), 128'(s_eof), 128'(tbl[t].exp_eof));
      if (!tbl[t].rnd_ready)
        chk($sformatf("t%0d_valid_cycles", t), 128'(s_vcyc), 128'(tbl[t].exp_win));
    end

    // Stall: window for pixel 10 held while pixel 11 waits.
    do_reset();
    s_rmode = 2; s_man = 1'b1;
    for (int i = 0; i < 11; i++) s_send(0, i / 4, i % 4);
    s_man = 1'b0;
    s_pix.data_in = W'(11); s_pix.data_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", 128'(s_pix.data_in_ready), 128'(0));
      chk("stall_data", 128'({s_win.win_valid, s_win.win_data, s_win.win_sof}),
          128'({1'b1, s_exp(0, 2, 2).d, 1'b1}));
    end
    @(posedge clk); #1;
    s_man = 1'b1;
    for (int i = 11; i < 16; i++) s_send(0, i / 4, i % 4);
    s_drain();
    chk("stall_windows", 128'(s_cnt), 128'(4));

    // Reset after pixel 9, then a fresh frame.
    do_reset();
    for (int i = 0; i < 10; i++) s_send(0, i / 4, i % 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    s_cnt = 0; s_sof = 0;
    for (int i = 0; i < 16; i++) s_send(0, i / 4, i % 4);
    s_drain();
    chk("midreset_windows", 128'(s_cnt), 128'(4));
    chk("midreset_sof", 128'(s_sof), 128'(1));

    // Larger frame, random valid gaps and random ready.
    b_cnt = 0; b_sof = 0; b_eol = 0; b_eof = 0;
    b_rmode = 1;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < BH; r++)
        for (int c = 0; c < BW; c++) begin
          img[r][c] = W'($urandom_range(0, 255));
          b_send(r, c);
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
    b_rmode = 0;
    for (int k = 0; k < 50 && bq.size() != 0; k++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    chk("big_drain_empty", 128'(bq.size()), 128'(0));
    chk("big_windows", 128'(b_cnt), 128'(2*(BW-2)*(BH-2)));
    chk("big_sof", 128'(b_sof), 128'(2));
    chk("big_eol", 128'(b_eol), 128'(2*(BH-2)));
    chk("big_eof", 128'(b_eof), 128'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv_window_3x3.md
# conv_window_3x3

Streaming 3x3 sliding-window generator for the convolution datapath. It sits directly downstream of the prefetch FIFO's read port: FIFO `rd_data`/`rd_vld` drive `data_in`/`data_in_valid`, and `data_in_ready` drives FIFO `rd_en`. It buffers two image lines internally and emits one full 3x3 pixel window per accepted pixel once the window lies entirely inside the frame, with a valid/ready handshake toward the convolution MAC array.

## Interface
Parameters:
- `W`, 8: pixel width in bits.
- `IMG_W`, 640: pixels per line. Must be at least 3.
- `IMG_H`, 480: lines per frame. Must be at least 3.
- Derived, local: `COL_W = clog2(IMG_W)` and `ROW_W = clog2(IMG_H)`.

Ports (clock and reset first):
- `clk`, in, 1: single clock, shared with the FIFO read side.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `data_in`, in, `W`: pixel in raster order, from FIFO `rd_data`.
- `data_in_valid`, in, 1: from FIFO `rd_vld`.
- `data_in_ready`, out, 1: to FIFO `rd_en`; this is the pop strobe.
- `win_data`, out, `9*W`: 3x3 window. Pixel at window row r (0 = oldest/top) and column c (0 = leftmost) sits at `win_data[W*(3*r+c) +: W]`.
- `win_valid`, out, 1: `win_data` and the flags below are valid.
- `win_ready`, in, 1: consumer accepts the window.
- `win_sof`, out, 1: first window of the frame (centre pixel at line 1, column 1).
- `win_eol`, out, 1: last window of a line (input column `IMG_W-1`).
- `win_eof`, out, 1: last window of the frame.

## Operation
- Accept condition: `acc = data_in_valid & data_in_ready`.
- `data_in_ready` is combinational: `data_in_ready = ~win_valid | win_ready`. There is a single output register stage and no skid buffer.
- Counters `col` (0..`IMG_W-1`) and `row` (0..`IMG_H-1`) advance only on `acc`.
  - `col` wraps to 0 after `IMG_W-1`, and `row` then increments.
  - `row` wraps to 0 after `IMG_H-1` in the same cycle that `col` wraps.
  - Consecutive frames run back-to-back with no gap cycle.
- Line buffers: two arrays, `lb0` (line `row-1`) and `lb1` (line `row-2`), each `IMG_W` x `W`.
  - Both are read asynchronously at address `col`, giving taps `t0 = lb0[col]` and `t1 = lb1[col]`.
  - On `acc`: `lb1[col] <= t0` and `lb0[col] <= data_in`.
  - Line buffer contents are never reset.
- Window registers: 3x3 array of `W`-bit registers. On `acc`, columns shift left (c1→c0, c2→c1) and the new column c2 is loaded as {r0: `t1`, r1: `t0`, r2: `data_in`}.
- Output gating:
  - On `acc` with `row>=2 && col>=2`, the cycle after `acc` presents: `win_valid=1`, `win_data` = the shifted window, `win_sof = (row==2 && col==2)`, `win_eol = (col==IMG_W-1)`, `win_eof = (row==IMG_H-1 && col==IMG_W-1)`.
  - On `acc` outside that region, or on no `acc` while `win_ready=1`, `win_valid` clears to 0.
  - While `win_valid & ~win_ready`, `win_data` and all flags hold stable and no input is accepted.
- Windows never straddle lines or frames. The first window of each line needs three fresh pixels of that line (col>=2), so stale shift-register contents are never emitted.
- Windows per frame: exactly `(IMG_W-2)*(IMG_H-2)`.

## Timing
- Reset (`rst_n=0` at a `clk` edge):
  - `col`, `row`, `win_valid`, `win_sof`, `win_eol`, `win_eof` and `win_data` all go to 0.
  - `data_in_ready` reads 1 during and after reset.
- Latency: a pixel accepted at cycle t yields its window with `win_valid=1` at cycle t+1.
- Throughput: one window per cycle when `data_in_valid` and `win_ready` are held high.
- Simultaneous `win_ready=1` with `acc`: the output register reloads in the same cycle, so there is no bubble.
- Reset mid-frame: the next accepted pixel is treated as line 0, column 0. Old line buffer contents are harmless because of the `row>=2` gate.
- Empty FIFO (`data_in_valid=0`): the window registers, counters and line buffers hold. Only `win_valid` drops, and only once the pending window has been taken.

## Test plan
1. `IMG_W=4`, `IMG_H=4`; pixel values = 4·row+col for one frame, streamed continuously with `win_ready=1`.
   - First window appears the cycle after pixel 10, with `win_sof=1`; `win_data` rows are {0,1,2}, {4,5,6}, {8,9,10}.
   - Exactly 4 windows; the last has centre 10 and bottom row {13,14,15}, with `win_eol=1` and `win_eof=1`.
2. Same stream with `win_ready` low for 3 cycles while a window is pending.
   - `data_in_ready=0` and `win_data` is unchanged for those 3 cycles.
   - No pixel is lost: total is 4 windows with the same values as test 1.
3. `data_in_valid` toggled in a 1-on, 2-off pattern.
   - Window contents match test 1.
   - `win_valid` is high only the cycle after each window-producing `acc` (with `win_ready=1`).
4. Two back-to-back frames, frame 2 pixels = 16 + 4·row + col.
   - Frame 2's first window is {16,17,18}, {20,21,22}, {24,25,26}, with `win_sof=1`.
   - No frame-1 pixel appears in any frame-2 window.
5. Assert `rst_n=0` for 1 cycle after pixel 9, then restart the frame from pixel 0.
   - All outputs read 0 after reset.
   - The first window after restart equals the test 1 first window.
6. Default `IMG_W=640`, `IMG_H=480`, random valid/ready.
   - Window count is 638·478 = 304964.
   - Exactly one `win_sof`, one `win_eof` and 478 `win_eol` per frame.
   - Every window matches a golden model.
